branch_resolve: RTL
===================

// Module: branch_resolve
// PURPOSE
//  Consumes the zero flag from the EX-stage zero detector and turns it into a branch decision.
//  Registers the decision into the EX/MEM boundary, redirects the PC and squashes wrong-path stages.
//  Sits between the ALU/zero-detect logic and the IF-stage PC mux / IF-ID, ID-EX pipeline registers.
// PARAMETERS
//  AW            32  PC / branch-target width in bits
//  FLUSH_CYCLES  2   cycles flush stays high per taken branch, including the redirect cycle; legal range 1..7
//  CW            16  event counter width; used only with BRANCH_STATS_EN
// PORTS
//  clk          in   1    pipeline clock, rising edge
//  reset_n      in   1    asynchronous, active-low reset
//  ex_valid     in   1    EX stage holds a real instruction
//  ex_branch    in   1    EX instruction is a conditional branch
//  ex_bne       in   1    0 = beq (taken on zero), 1 = bne (taken on non-zero)
//  ex_zero      in   1    zero flag from the EX-stage zero detector (1 = ALU result == 0)
//  ex_target    in   AW   computed branch target
//  stall        in   1    pipeline hold; freezes all state in this block
//  pc_sel       out  1    1 = IF loads pc_target instead of PC+4
//  pc_target    out  AW   registered redirect address
//  flush        out  1    squash IF/ID and ID/EX contents
//  busy         out  1    redirect/squash sequence in progress
//  br_count     out  CW   branches resolved; only with BRANCH_STATS_EN
//  tk_count     out  CW   branches taken; only with BRANCH_STATS_EN
// BEHAVIOUR
//  - taken = ex_valid & ex_branch & (ex_zero ^ ex_bne); evaluated combinationally, acted on at the clk edge.
//  - reset_n low, asynchronous: state=IDLE, pc_sel=0, flush=0, busy=0, pc_target=0, counters=0.
//  - FSM states: IDLE, REDIRECT, SQUASH. Down-counter sq_cnt is 3 bits wide.
//  - IDLE:     taken & !stall -> REDIRECT; pc_target <= ex_target. Otherwise stay in IDLE.
//  - REDIRECT: pc_sel=1, flush=1, busy=1; lasts exactly 1 unstalled cycle.
//              If FLUSH_CYCLES==1, go to IDLE. Else go to SQUASH with sq_cnt <= FLUSH_CYCLES-2.
//  - SQUASH:   pc_sel=0, flush=1, busy=1. At sq_cnt==0 go to IDLE; otherwise sq_cnt decrements.
//  - All outputs decode from registered state, so latency is 1 clk from the taken edge to pc_sel/flush.
//  - In IDLE: pc_sel=0, flush=0, busy=0. pc_target holds its last value and is not cleared.
//  - While busy, EX inputs are wrong-path: taken is ignored and counters do not count.
//  - stall=1: state, sq_cnt, pc_target and counters hold; outputs stay at their current values.
//    A taken branch present during a stall is captured on the first unstalled edge.
//  - Not-taken branch, or ex_valid=0: no state change.
//  - Reset mid-sequence: returns to IDLE immediately; flush and pc_sel drop asynchronously.
// CONFIGURATION
//  - BRANCH_STATS_EN defined:
//    br_count increments on each resolved branch (ex_valid & ex_branch & !busy & !stall).
//    tk_count increments on each taken branch under the same qualifier.
//    Both counters wrap modulo 2^CW.
//  - BRANCH_STATS_EN undefined: br_count, tk_count and the counter logic are absent from the port list.
//    Decision and flush behaviour is identical to the defined case.
// TESTING
//  - Reset: hold reset_n=0 with taken inputs active -> pc_sel=0, flush=0, busy=0, pc_target=0.
//  - beq: ex_zero=1, ex_bne=0, ex_target=0x0000_0040 -> next cycle pc_sel=1, flush=1, pc_target=0x40.
//    flush then stays high 2 cycles total (FLUSH_CYCLES=2), and busy falls with it.
//  - Not taken: bne with ex_zero=1 -> pc_sel and flush stay 0. Also beq with ex_zero=0 -> pc_sel and flush stay 0.
//  - Wrong path: a second taken branch presented during REDIRECT/SQUASH -> ignored.
//    pc_target is unchanged and no extra flush cycles occur.
//  - Stall: assert stall 3 cycles in the REDIRECT state -> pc_sel and flush held for those 3 cycles.
//    SQUASH follows once stall drops. FLUSH_CYCLES=1 build -> flush is high exactly 1 unstalled cycle.
//  - BRANCH_STATS_EN: 5 branches, 3 taken, none while busy -> br_count=5, tk_count=3.
//    Preload both counters to 0xFFFF and resolve one taken branch -> both wrap to 0.

Source files
------------

// File: rtl/branch_resolve_if.sv
// EX-stage branch resolution bus: EX decision inputs plus PC redirect / squash outputs.
// The br_count/tk_count statistics signals exist only when BRANCH_STATS_EN is defined.
interface branch_resolve_if #(
    parameter int AW = 32,
    parameter int CW = 16
);
    logic          ex_valid;
    logic          ex_branch;
    logic          ex_bne;
    logic          ex_zero;
    logic [AW-1:0] ex_target;
    logic          stall;
    logic          pc_sel;
    logic [AW-1:0] pc_target;
    logic          flush;
    logic          busy;
`ifdef BRANCH_STATS_EN
    logic [CW-1:0] br_count;
    logic [CW-1:0] tk_count;

    modport master (
        output ex_valid, ex_branch, ex_bne, ex_zero, ex_target, stall,
        input  pc_sel, pc_target, flush, busy, br_count, tk_count
    );
    modport slave (
        input  ex_valid, ex_branch, ex_bne, ex_zero, ex_target, stall,
        output pc_sel, pc_target, flush, busy, br_count, tk_count
    );
`else
    modport master (
        output ex_valid, ex_branch, ex_bne, ex_zero, ex_target, stall,
        input  pc_sel, pc_target, flush, busy
    );
    modport slave (
        input  ex_valid, ex_branch, ex_bne, ex_zero, ex_target, stall,
        output pc_sel, pc_target, flush, busy
    );
`endif
endinterface

// File: rtl/branch_resolve.sv
// Turns the EX zero flag into a branch decision, redirects the PC and squashes wrong-path stages.
// Optional feature: define BRANCH_STATS_EN to add resolved/taken branch counters.
module branch_resolve #(
    parameter int AW           = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CW           = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    branch_resolve_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        SQUASH   = 2'd2
    } state_t;

    localparam logic [2:0] SQ_INIT = (FLUSH_CYCLES >= 2) ? 3'(FLUSH_CYCLES - 2) : 3'd0;

    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7 || AW < 1 || CW < 1) begin : g_bad_cfg
        $error("branch_resolve: FLUSH_CYCLES must be 1..7, AW and CW at least 1");
    end

    state_t        state;
    logic [2:0]    sq_cnt;
    logic          pc_sel_q;
    logic          flush_q;
    logic          busy_q;
    logic [AW-1:0] pc_target_q;
    logic          taken;

    assign taken = bus.ex_valid & bus.ex_branch & (bus.ex_zero ^ bus.ex_bne);

    // Outputs are registered alongside the state so they never glitch on EX inputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            sq_cnt      <= 3'd0;
            pc_sel_q    <= 1'b0;
            flush_q     <= 1'b0;
            busy_q      <= 1'b0;
            pc_target_q <= '0;
        end else if (!bus.stall) begin
            case (state)
                IDLE: begin
                    if (taken) begin
                        state       <= REDIRECT;
                        pc_target_q <= bus.ex_target;
                        pc_sel_q    <= 1'b1;
                        flush_q     <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                REDIRECT: begin
                    pc_sel_q <= 1'b0;
                    if (FLUSH_CYCLES == 1) begin
                        state   <= IDLE;
                        flush_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else begin
                        state  <= SQUASH;
                        sq_cnt <= SQ_INIT;
                    end
                end
                SQUASH: begin
                    if (sq_cnt == 3'd0) begin
                        state   <= IDLE;
                        flush_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else begin
                        sq_cnt <= sq_cnt - 3'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    pc_sel_q <= 1'b0;
                    flush_q  <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc_sel    = pc_sel_q;
    assign bus.flush     = flush_q;
    assign bus.busy      = busy_q;
    assign bus.pc_target = pc_target_q;

`ifdef BRANCH_STATS_EN
    logic [CW-1:0] br_cnt;
    logic [CW-1:0] tk_cnt;
    logic          resolved;

    // Branches seen while busy are wrong-path and must not be counted.
    assign resolved = bus.ex_valid & bus.ex_branch & ~busy_q & ~bus.stall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            br_cnt <= '0;
            tk_cnt <= '0;
        end else begin
            if (resolved) begin
                br_cnt <= br_cnt + CW'(1);
            end
            if (resolved && taken) begin
                tk_cnt <= tk_cnt + CW'(1);
            end
        end
    end

    assign bus.br_count = br_cnt;
    assign bus.tk_count = tk_cnt;
`endif

endmodule
